// File: rtl/sata_dbg_probe_arb_pkg.sv
// sata_dbg_probe_arb_pkg
//   Shared definitions for the SATA debug probe arbiter: arbiter state
//   encodings, the default debug bus width (ILA TRIG0 width), the ILA
//   CONTROL port width and the saturating helper for the drop counter.
package sata_dbg_probe_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ARMED  = 2'd1,
    ST_HOLD   = 2'd2,
    ST_FROZEN = 2'd3
  } arb_state_e;

  localparam int unsigned DBG_DW_DEFAULT = 192;
  localparam int unsigned ILA_CTRL_W     = 36;
  localparam int unsigned DROP_W         = 8;

  // Adds up to 15 lost events to the drop counter, pinning at all-ones.
  function automatic logic [DROP_W-1:0] sat_add_drop(input logic [DROP_W-1:0] cnt,
                                                     input logic [3:0]        inc);
    logic [DROP_W:0] sum;
    sum = {1'b0, cnt} + (DROP_W+1)'(inc);
    if (sum[DROP_W]) return {DROP_W{1'b1}};
    return sum[DROP_W-1:0];
  endfunction

endpackage

// File: rtl/sata_dbg_probe_arb_rr_pick.sv
// sata_dbg_rr_pick
//   Combinational round-robin picker. The search starts at last_i+1 and
//   wraps around, so the most recently granted source has lowest priority.
//   Ports:
//     req_i   [C_NUM_SRC]  request vector
//     last_i  [C_SEL_W]    index granted last time
//     grant_o [C_SEL_W]    chosen index (0 when no request)
//     any_o                at least one request present
module sata_dbg_rr_pick
  import sata_dbg_probe_arb_pkg::*;
#(
  parameter int C_NUM_SRC = 4,
  parameter int C_SEL_W   = 2
) (
  input  logic [C_NUM_SRC-1:0] req_i,
  input  logic [C_SEL_W-1:0]   last_i,
  output logic [C_SEL_W-1:0]   grant_o,
  output logic                 any_o
);

  logic found;
  int   idx;

  always_comb begin
    grant_o = '0;
    found   = 1'b0;
    idx     = 0;
    for (int k = 1; k <= C_NUM_SRC; k++) begin
      idx = (int'(last_i) + k) % C_NUM_SRC;
      if (!found && req_i[idx]) begin
        grant_o = C_SEL_W'(idx);
        found   = 1'b1;
      end
    end
  end

  assign any_o = |req_i;

endmodule

// File: rtl/sata_dbg_probe_arb.sv
// sata_dbg_probe_arb
//   Shares one ChipScope ILA TRIG0 port among several SATA debug buses.
//   In fixed mode the source comes from sel_fixed; in event mode the block
//   round-robins to sources raising src_event, holding each grant for at
//   least C_HOLD cycles, and freezes the selection once the ILA triggers.
//   Ports:
//     clk        capture clock (also clocks the ILA)
//     rst        synchronous active-high reset
//     src_data   packed debug buses, source i at [i*C_DW +: C_DW]
//     src_event  per-source capture requests
//     sel_mode   0 = fixed, 1 = event driven
//     sel_fixed  source used while idle (out of range loads 0)
//     arm        enables event-driven arbitration
//     ila_trig   ILA TRIG_OUT
//     trig0      to ILA TRIG0, one cycle behind the selected source
//     cur_sel    currently selected source
//     busy       arbiter is not idle
//     drop_cnt   saturating count of coalesced events
//   Build option: define SATA_DBG_TAG_EN to overwrite the top C_SEL_W+1
//   bits of trig0 with {switch, cur_sel} so captures self-identify.
module sata_dbg_probe_arb
  import sata_dbg_probe_arb_pkg::*;
#(
  parameter int C_NUM_SRC = 4,
  parameter int C_DW      = DBG_DW_DEFAULT,
  parameter int C_SEL_W   = 2,
  parameter int C_HOLD    = 1024
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [C_NUM_SRC*C_DW-1:0] src_data,
  input  logic [C_NUM_SRC-1:0]      src_event,
  input  logic                      sel_mode,
  input  logic [C_SEL_W-1:0]        sel_fixed,
  input  logic                      arm,
  input  logic                      ila_trig,
  output logic [C_DW-1:0]           trig0,
  output logic [C_SEL_W-1:0]        cur_sel,
  output logic                      busy,
  output logic [DROP_W-1:0]         drop_cnt
);

  localparam int HOLD_W = $clog2(C_HOLD);

  arb_state_e             state_q;
  logic [C_SEL_W-1:0]     cur_sel_q;
  logic [C_SEL_W-1:0]     last_q;
  logic [C_NUM_SRC-1:0]   pending_q;
  logic [HOLD_W-1:0]      hold_q;
  logic [DROP_W-1:0]      drop_q;
  logic                   busy_q;
  logic [C_DW-1:0]        trig_q;
  logic [C_DW-1:0]        trig_d;

  logic [C_NUM_SRC-1:0]   req;
  logic [C_NUM_SRC-1:0]   grant_oh;
  logic [C_SEL_W-1:0]     grant;
  logic                   any;
  logic [C_SEL_W-1:0]     fixed_sel;
  logic [3:0]             drop_inc;
  logic [C_DW-1:0]        slice;

  function automatic logic [3:0] popcnt(input logic [C_NUM_SRC-1:0] v);
    logic [3:0] n;
    n = '0;
    for (int i = 0; i < C_NUM_SRC; i++) n = n + 4'(v[i]);
    return n;
  endfunction

  assign req       = pending_q | src_event;
  assign grant_oh  = C_NUM_SRC'(1) << grant;
  assign fixed_sel = ({{(32-C_SEL_W){1'b0}}, sel_fixed} < 32'(C_NUM_SRC)) ? sel_fixed : '0;
  // A new event on a bit that is already pending is coalesced and lost.
  assign drop_inc  = popcnt(src_event & pending_q);

  sata_dbg_rr_pick #(
    .C_NUM_SRC(C_NUM_SRC),
    .C_SEL_W  (C_SEL_W)
  ) u_pick (
    .req_i  (req),
    .last_i (last_q),
    .grant_o(grant),
    .any_o  (any)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      cur_sel_q <= '0;
      last_q    <= C_SEL_W'(C_NUM_SRC-1);
      pending_q <= '0;
      hold_q    <= '0;
      drop_q    <= '0;
      busy_q    <= 1'b0;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          cur_sel_q <= fixed_sel;
          pending_q <= '0;
          if (arm && sel_mode) begin
            state_q <= ST_ARMED;
            busy_q  <= 1'b1;
          end
        end
        ST_ARMED: begin
          if (!arm) begin
            state_q   <= ST_IDLE;
            pending_q <= '0;
            busy_q    <= 1'b0;
          end else if (ila_trig) begin
            // Trigger wins over a same-cycle grant; requests are remembered.
            state_q   <= ST_FROZEN;
            pending_q <= req;
          end else if (any) begin
            cur_sel_q <= grant;
            last_q    <= grant;
            pending_q <= req & ~grant_oh;
            hold_q    <= HOLD_W'(C_HOLD-1);
            state_q   <= ST_HOLD;
          end
        end
        ST_HOLD: begin
          if (!arm) begin
            state_q   <= ST_IDLE;
            pending_q <= '0;
            busy_q    <= 1'b0;
          end else begin
            pending_q <= pending_q | src_event;
            drop_q    <= sat_add_drop(drop_q, drop_inc);
            if (ila_trig)          state_q <= ST_FROZEN;
            else if (hold_q == '0) state_q <= ST_ARMED;
            else                   hold_q  <= hold_q - HOLD_W'(1);
          end
        end
        ST_FROZEN: begin
          if (!arm) begin
            state_q   <= ST_IDLE;
            pending_q <= '0;
            busy_q    <= 1'b0;
          end else begin
            pending_q <= pending_q | src_event;
            drop_q    <= sat_add_drop(drop_q, drop_inc);
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign slice = src_data[int'(cur_sel_q)*C_DW +: C_DW];

`ifdef SATA_DBG_TAG_EN
  // sel_prev_q lags cur_sel_q by one cycle, so a mismatch marks the first
  // trig0 sample taken from a newly selected source.
  logic [C_SEL_W-1:0] sel_prev_q;

  always_ff @(posedge clk) begin
    if (rst) sel_prev_q <= '0;
    else     sel_prev_q <= cur_sel_q;
  end

  always_comb begin
    trig_d = slice;
    trig_d[C_DW-1 -: C_SEL_W+1] = {cur_sel_q != sel_prev_q, cur_sel_q};
  end
`else
  assign trig_d = slice;
`endif

  // Output register stage feeding the ILA.
  always_ff @(posedge clk) begin
    if (rst) trig_q <= '0;
    else     trig_q <= trig_d;
  end

  assign trig0    = trig_q;
  assign cur_sel  = cur_sel_q;
  assign busy     = busy_q;
  assign drop_cnt = drop_q;

endmodule

// File: tb/tb_sata_dbg_probe_arb.sv
// Directed bench for sata_dbg_probe_arb with a trig0 scoreboard.
module tb_sata_dbg_probe_arb;

  localparam int N    = 4;
  localparam int DW   = 192;
  localparam int SW   = 2;
  localparam int HOLD = 16;
`ifdef SATA_DBG_TAG_EN
  localparam bit TAG_EN = 1'b1;
`else
  localparam bit TAG_EN = 1'b0;
`endif

  logic            clk = 1'b0;
  logic            rst;
  logic [N*DW-1:0] src_data;
  logic [N-1:0]    src_event;
  logic            sel_mode;
  logic [SW-1:0]   sel_fixed;
  logic            arm;
  logic            ila_trig;
  logic [DW-1:0]   trig0;
  logic [SW-1:0]   cur_sel;
  logic            busy;
  logic [7:0]      drop_cnt;

  int errors = 0;
  int checks = 0;

  logic [DW-1:0] sl [N];

  typedef struct {
    string         tag;
    logic [DW-1:0] val;
  } exp_t;
  exp_t sb[$];

  sata_dbg_probe_arb #(
    .C_NUM_SRC(N), .C_DW(DW), .C_SEL_W(SW), .C_HOLD(HOLD)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .src_data (src_data),
    .src_event(src_event),
    .sel_mode (sel_mode),
    .sel_fixed(sel_fixed),
    .arm      (arm),
    .ila_trig (ila_trig),
    .trig0    (trig0),
    .cur_sel  (cur_sel),
    .busy     (busy),
    .drop_cnt (drop_cnt)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic pack_src();
    for (int i = 0; i < N; i++) src_data[i*DW +: DW] = sl[i];
  endtask

  function automatic logic [DW-1:0] exp_trig(int s, bit sw);
    logic [DW-1:0] v;
    v = sl[s];
    if (TAG_EN) v[DW-1 -: SW+1] = {sw, SW'(s)};
    return v;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_wide(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic push(input string tag, input int s, input bit sw);
    exp_t e;
    e.tag = tag;
    e.val = exp_trig(s, sw);
    sb.push_back(e);
  endtask

  // Advance one cycle and compare trig0 against the oldest expectation.
  task automatic step_trig();
    exp_t e;
    step();
    if (sb.size() == 0) begin
      checks++;
      errors++;
      $error("FAIL scoreboard: got empty queue expected an entry");
    end else begin
      e = sb.pop_front();
      chk_wide(e.tag, trig0, e.val);
    end
  endtask

  initial begin
    rst = 1'b1; sel_mode = 1'b0; sel_fixed = '0; arm = 1'b0;
    ila_trig = 1'b0; src_event = '0;
    for (int i = 0; i < N; i++) sl[i] = {24{8'(8'h10 + i)}};
    sl[2] = {24{8'hA5}};
    pack_src();
    step(); step();
    chk("rst_cur_sel", cur_sel, 0);
    chk("rst_busy", busy, 0);
    chk("rst_drop", drop_cnt, 0);
    chk_wide("rst_trig0", trig0, '0);

    // Fixed selection.
    rst = 1'b0; sel_fixed = 2'd2;
    step();
    chk("idle_cur_sel", cur_sel, 2);
    push("idle_trig_src2", 2, 1'b1);
    step_trig();
    sl[2] = {24{8'h3C}}; pack_src();
    push("idle_data_latency", 2, 1'b0);
    step_trig();
    chk("idle_busy", busy, 0);
    arm = 1'b1;
    step();
    chk("mode0_ignores_arm", busy, 0);

    // Event-driven round-robin.
    sel_mode = 1'b1;
    step();
    chk("armed_busy", busy, 1);
    src_event = 4'b1010;
    step();                                   // grant edge
    src_event = '0;
    chk("rr_first_grant", cur_sel, 1);
    push("grant_trig_t2", 1, 1'b1);
    step_trig();                              // hold edge 1
    src_event = 4'b0001; step(); src_event = '0;  // edge 2: sets pending[0]
    step();
    src_event = 4'b0001; step(); src_event = '0;  // edge 4: drop
    step();
    src_event = 4'b0001; step(); src_event = '0;  // edge 6: drop
    chk("hold_drop_cnt", drop_cnt, 2);
    repeat (10) step();                       // edge 16: last hold cycle
    chk("hold_min_window", cur_sel, 1);
    step();
    chk("pending_grant_3", cur_sel, 3);
    push("switch_tag_first", 3, 1'b1);
    step_trig();
    push("switch_tag_second", 3, 1'b0);
    step_trig();
    repeat (14) step();
    chk("hold_second_window", cur_sel, 3);
    step();
    chk("pending_grant_0", cur_sel, 0);

    // Disarm mid-hold.
    repeat (3) step();
    arm = 1'b0; sel_fixed = 2'd2;
    step();
    chk("disarm_busy", busy, 0);
    step();
    chk("disarm_follow_fixed", cur_sel, 2);
    chk("disarm_drop_kept", drop_cnt, 2);

    // Trigger freeze.
    arm = 1'b1;
    step();
    ila_trig = 1'b1; src_event = 4'b0100;
    step();
    ila_trig = 1'b0; src_event = '0;
    chk("freeze_cur_sel", cur_sel, 2);
    chk("freeze_busy", busy, 1);
    step();
    src_event = 4'b0010; step(); src_event = '0;
    step();
    src_event = 4'b0010; step(); src_event = '0;
    chk("frozen_drop", drop_cnt, 3);
    chk("frozen_holds_sel", cur_sel, 2);
    arm = 1'b0; sel_fixed = 2'd0;
    step();
    chk("unfreeze_busy", busy, 0);
    step();
    chk("unfreeze_fixed", cur_sel, 0);
    arm = 1'b1;
    step(); step(); step();
    chk("pending_cleared", cur_sel, 0);
    chk("rearmed_busy", busy, 1);

    // Drop counter saturation while frozen.
    ila_trig = 1'b1;
    step();
    ila_trig = 1'b0; src_event = 4'b1111;
    repeat (71) step();
    src_event = '0;
    chk("drop_saturates", drop_cnt, 255);
    chk("sat_still_frozen", cur_sel, 0);

    // Reset in the middle of a hold window.
    arm = 1'b0; step();
    arm = 1'b1; step();
    src_event = 4'b0100; step(); src_event = '0;
    chk("rr_after_last0", cur_sel, 2);
    repeat (3) step();
    rst = 1'b1;
    step();
    chk("midhold_rst_sel", cur_sel, 0);
    chk("midhold_rst_busy", busy, 0);
    chk("midhold_rst_drop", drop_cnt, 0);
    chk_wide("midhold_rst_trig0", trig0, '0);
    rst = 1'b0; sel_fixed = 2'd2;
    step();                                   // IDLE -> ARMED, loads 2
    chk("post_rst_armed_sel", cur_sel, 2);
    src_event = 4'b1111;
    step();
    src_event = '0;
    chk("post_rst_first_is_0", cur_sel, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
